// File: rtl/dm_responder_if.sv
// Data-memory port between the CPU load/store unit (master) and dm_responder (slave).
interface dm_responder_if;
    logic [31:0] data_addr;
    logic [31:0] data_wd;
    logic [3:0]  data_byte_we;
    logic [31:0] data_pc;
    logic [31:0] data_rd;
    logic        busy;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport master (
        output data_addr, data_wd, data_byte_we, data_pc,
        input  data_rd, busy, trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  data_addr, data_wd, data_byte_we, data_pc,
        output data_rd, busy, trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: combinational read, byte-lane merged writes, zeroing sweep after reset.
// Optional write-trace record enabled by defining DM_TRACE_EN.
module dm_responder #(
    parameter int unsigned DEPTH_LOG2 = 12
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int unsigned WORDS = 2 ** DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   count;
    logic [IDX_W-1:0]   count_nxt;
    logic [31:0]        mem [WORDS];

    logic [IDX_W-1:0]   idx;
    logic [31:0]        old_word;
    logic [31:0]        merged;
    logic               busy_c;
    logic               commit;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [31:0]        mem_wdata;
    logic               unused_bits;

    // Byte offset and bits above the array are dropped: addresses wrap silently.
    assign idx      = bus.data_addr[DEPTH_LOG2+1:2];
    assign old_word = mem[idx];
    assign busy_c   = (state == CLEAR);
    assign commit   = !busy_c && (bus.data_byte_we != 4'b0000);

    assign bus.busy    = busy_c;
    assign bus.data_rd = busy_c ? 32'h0 : old_word;

    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.data_byte_we[i]) begin
                merged[8*i +: 8] = bus.data_wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // The sweep owns the write port while CLEAR; only RUN accepts initiator stores.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_wdata = merged;
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = count;
                mem_wdata = 32'h0;
                count_nxt = count + IDX_W'(1);
                if (&count) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                mem_we = commit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

    assign unused_bits = ^{bus.data_addr, bus.data_pc};

`ifdef DM_TRACE_EN
    logic        trace_valid_q;
    logic [31:0] trace_pc_q;
    logic [31:0] trace_addr_q;
    logic [31:0] trace_data_q;

    // One record per committed store; a reset edge suppresses the store and its record.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= 32'h0;
            trace_addr_q  <= 32'h0;
            trace_data_q  <= 32'h0;
        end else begin
            trace_valid_q <= commit;
            if (commit) begin
                trace_pc_q   <= bus.data_pc;
                trace_addr_q <= {bus.data_addr[31:2], 2'b00};
                trace_data_q <= merged;
            end
        end
    end

    assign bus.trace_valid = trace_valid_q;
    assign bus.trace_pc    = trace_pc_q;
    assign bus.trace_addr  = trace_addr_q;
    assign bus.trace_data  = trace_data_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (trace_valid_q) begin
            $display("@%h: *%h <= %h", trace_pc_q, trace_addr_q, trace_data_q);
        end
    end
`endif
`else
    assign bus.trace_valid = 1'b0;
    assign bus.trace_pc    = 32'h0;
    assign bus.trace_addr  = 32'h0;
    assign bus.trace_data  = 32'h0;
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder (DEPTH_LOG2=4): vector table plus trace scoreboard.
module tb_dm_responder;
`ifdef DM_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    dm_responder_if bus ();

    dm_responder #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [3:0]  we;
        logic [31:0] exp_pre;
        logic [31:0] exp_post;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trec_t;

    vec_t  vecs [8];
    trec_t sb [$];
    int    n_checks;
    int    n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] we, input logic [31:0] pc);
        bus.data_addr    = addr;
        bus.data_wd      = wd;
        bus.data_byte_we = we;
        bus.data_pc      = pc;
    endtask

    // Counts edges until busy drops, bounded so a stuck sweep still terminates.
    task automatic run_sweep(input int start, output int n);
        n = start;
        while (bus.busy === 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic check_trace_record();
        trec_t t;
        if (sb.size() > 0) begin
            t = sb.pop_front();
            check("trace_valid", 32'(bus.trace_valid), TRACE_ON ? 32'h1 : 32'h0);
            check("trace_pc",    bus.trace_pc,   TRACE_ON ? t.pc   : 32'h0);
            check("trace_addr",  bus.trace_addr, TRACE_ON ? t.addr : 32'h0);
            check("trace_data",  bus.trace_data, TRACE_ON ? t.data : 32'h0);
        end else begin
            check("trace_idle", 32'(bus.trace_valid), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks = 0;
        n_pass   = 0;

        vecs[0] = '{32'h0000_0008, 32'h1234_5678, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'h1234_5678};
        vecs[1] = '{32'h0000_0008, 32'h00AB_0000, 32'h0000_0104, 4'b0100, 32'h1234_5678, 32'h12AB_5678};
        vecs[2] = '{32'h0000_0008, 32'h0000_00CD, 32'h0000_0108, 4'b0001, 32'h12AB_5678, 32'h12AB_56CD};
        vecs[3] = '{32'h0000_0048, 32'hA5A5_A5A5, 32'h0000_010C, 4'b1111, 32'h12AB_56CD, 32'hA5A5_A5A5};
        vecs[4] = '{32'h0000_000B, 32'h0000_3C00, 32'h0000_0110, 4'b0010, 32'hA5A5_A5A5, 32'hA5A5_3CA5};
        vecs[5] = '{32'h0000_0030, 32'hFFFF_FFFF, 32'h0000_0114, 4'b0000, 32'h0000_0000, 32'h0000_0000};
        vecs[6] = '{32'h0000_003C, 32'h7700_0000, 32'h0000_0118, 4'b1000, 32'h0000_0000, 32'h7700_0000};
        vecs[7] = '{32'hFFFF_FFFD, 32'h0000_BEEF, 32'h0000_011C, 4'b0011, 32'h7700_0000, 32'h7700_BEEF};

        // Reset state
        reset = 1'b1;
        drive(32'h0000_0014, 32'h0, 4'b0000, 32'h0);
        tick();
        tick();
        check("rst_busy",        32'(bus.busy), 32'h1);
        check("rst_data_rd",     bus.data_rd, 32'h0);
        check("rst_trace_valid", 32'(bus.trace_valid), 32'h0);
        check("rst_trace_pc",    bus.trace_pc, 32'h0);
        check("rst_trace_addr",  bus.trace_addr, 32'h0);
        check("rst_trace_data",  bus.trace_data, 32'h0);
        reset = 1'b0;
        run_sweep(0, n);
        check("first_sweep_len", 32'(n), 32'd16);

        // Preload word 5, then a one-cycle reset pulse must clear it
        drive(32'h0000_0014, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0050);
        tick();
        check("preload_rd", bus.data_rd, 32'hDEAD_BEEF);
        bus.data_byte_we = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pulse_busy",        32'(bus.busy), 32'h1);
        check("pulse_rd_forced",   bus.data_rd, 32'h0);
        check("pulse_trace_clear", 32'(bus.trace_valid), 32'h0);
        run_sweep(0, n);
        check("pulse_sweep_len", 32'(n), 32'd16);
        check("cleared_word5",   bus.data_rd, 32'h0);

        // Vector table: same-cycle old read, next-cycle new read, trace record
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].pc);
            if (vecs[i].we != 4'b0000)
                sb.push_back('{vecs[i].pc, {vecs[i].addr[31:2], 2'b00}, vecs[i].exp_post});
            #1;
            check($sformatf("vec%0d_pre", i), bus.data_rd, vecs[i].exp_pre);
            tick();
            check($sformatf("vec%0d_post", i), bus.data_rd, vecs[i].exp_post);
            check_trace_record();
        end
        bus.data_byte_we = 4'b0000;
        tick();
        check("trace_pulse_end", 32'(bus.trace_valid), 32'h0);

        // Writes during the sweep are dropped and untraced
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        drive(32'h0000_003C, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0200);
        tick();
        check("busy_wr1_trace", 32'(bus.trace_valid), 32'h0);
        check("busy_wr1_busy",  32'(bus.busy), 32'h1);
        drive(32'h0000_0004, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0204);
        tick();
        check("busy_wr2_trace", 32'(bus.trace_valid), 32'h0);
        bus.data_byte_we = 4'b0000;
        run_sweep(4, n);
        check("busy_wr_sweep_len", 32'(n), 32'd16);
        bus.data_addr = 32'h0000_003C;
        #1;
        check("busy_wr_word15", bus.data_rd, 32'h0);
        bus.data_addr = 32'h0000_0004;
        #1;
        check("busy_wr_word1", bus.data_rd, 32'h0);

        // Fill every word with a non-zero pattern
        for (int i = 0; i < 16; i++) begin
            drive(32'(i * 4), {4{8'(i + 1)}}, 4'b1111, 32'h0000_0300);
            tick();
        end
        bus.data_byte_we = 4'b0000;
        bus.data_addr = 32'h0000_003C;
        #1;
        check("fill_word15", bus.data_rd, 32'h1010_1010);

        // Reset coinciding with a write: no commit, no trace; held reset keeps busy
        reset = 1'b1;
        drive(32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0400);
        tick();
        check("rst_wr_trace", 32'(bus.trace_valid), 32'h0);
        bus.data_byte_we = 4'b0000;
        bus.data_addr = 32'h0000_003C;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_hold_busy%0d", i), 32'(bus.busy), 32'h1);
        end
        check("rst_hold_rd_forced", bus.data_rd, 32'h0);
        reset = 1'b0;

        // Restart the sweep at cycle 10
        for (int i = 0; i < 10; i++) tick();
        check("mid_sweep_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_sweep(0, n);
        check("restart_sweep_len", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            bus.data_addr = 32'(i * 4);
            #1;
            check($sformatf("restart_word%0d", i), bus.data_rd, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
# dm_responder

Memory-side responder for the M-stage data-memory port. It accepts the word address, pre-lane-aligned write data, 4-bit byte-write enables and PC driven by the CPU-side load/store unit. It returns the addressed word combinationally on `data_rd`. After reset it sweeps the whole array to zero, and it publishes a registered one-cycle write-trace record for every committed store.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: log2 of the word count; the array holds 2^DEPTH_LOG2 32-bit words.

Ports:
- `clk` input 1: the block's single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `data_addr` input 32: byte address from the initiator; the word index is `data_addr[DEPTH_LOG2+1:2]`.
- `data_wd` input 32: write data, already shifted into the target byte lanes by the initiator.
- `data_byte_we` input 4: per-lane write enable; bit i covers bits [8i+7:8i]. The value 0000 means no write.
- `data_pc` input 32: PC of the instruction issuing the access; used only for trace.
- `data_rd` output 32: combinational read of the addressed word.
- `busy` output 1: clear sweep in progress.
- `trace_valid` output 1: one-cycle pulse, the cycle after a committed write.
- `trace_pc` output 32: PC of the traced write.
- `trace_addr` output 32: word-aligned address of the traced write, `{data_addr[31:2],2'b00}`.
- `trace_data` output 32: full merged word written.

## Operation
- Address decode:
  - Bits [1:0] are ignored; byte/half placement is the initiator's job and arrives via `data_byte_we`.
  - Bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the array size. No error is raised.
- Read:
  - `data_rd` = mem[index], purely combinational.
  - `data_rd` is forced to 0 while `busy`=1.
- Write commit:
  - Condition: `busy`=0 and `data_byte_we`≠0 at a rising edge.
  - Merged word: lane i = `data_wd` lane i if `data_byte_we[i]`, else the old mem lane i.
  - mem[index] ← merged word.
- Writes while `busy`=1 are dropped silently and produce no trace.
- Clear FSM has two states, CLEAR and RUN:
  - `reset`=1 at an edge → state CLEAR, counter ← 0.
  - In CLEAR with `reset`=0: mem[counter] ← 0 and counter ← counter+1. When counter = 2^DEPTH_LOG2−1, state ← RUN.
  - RUN is held until the next reset.
- `busy` = (state == CLEAR), decoded directly from the state register.
- Counter width is DEPTH_LOG2 bits. It wraps to 0 at the CLEAR→RUN transition; its value is don't-care in RUN.

## Timing
- Reset values:
  - `busy`=1 (state CLEAR).
  - `trace_valid`=0, `trace_pc`=0, `trace_addr`=0, `trace_data`=0.
  - Memory contents are not guaranteed until the sweep ends.
- Sweep length:
  - `busy` falls exactly 2^DEPTH_LOG2 rising edges after the last edge at which `reset`=1.
  - Reset held high keeps counter at 0 and `busy` at 1.
  - Reset asserted mid-sweep restarts the sweep from word 0.
- Read latency is 0 cycles. A read of the address being written in the same cycle returns the old value; the new value is visible the cycle after the commit edge.
- Back-to-back writes to the same word on consecutive cycles merge against the value from the previous commit; there are no lost lanes.
- Trace:
  - Trace outputs are registered at the commit edge, so they are valid the following cycle.
  - `trace_valid` is high for exactly one cycle per write. With consecutive writes, `trace_valid` stays high and the record updates every cycle.
  - Reset clears `trace_valid` to 0 on the same edge as a write would have committed; such a write does not commit.

## Configuration
- `DM_TRACE_EN` defined:
  - Trace registers are built as described.
  - A simulation-only `$display` prints `@<trace_pc>: *<trace_addr> <= <trace_data>` whenever `trace_valid`=1.
- `DM_TRACE_EN` not defined:
  - No trace registers are synthesised.
  - `trace_valid`, `trace_pc`, `trace_addr` and `trace_data` are tied to 0.
  - Memory, read and clear behaviour is unchanged.

## Test plan
All scenarios use DEPTH_LOG2=4 (16 words).
- Clear sweep:
  - Preload mem[5]=0xDEADBEEF, pulse `reset` for 1 cycle → `busy`=1 for exactly 16 cycles, then 0.
  - Read 0x14 → 0x00000000.
- Full-word write:
  - `data_addr`=0x08, `data_byte_we`=1111, `data_wd`=0x12345678 → next cycle `data_rd`@0x08 = 0x12345678.
  - With `DM_TRACE_EN`: `trace_valid`=1 for 1 cycle, `trace_addr`=0x08, `trace_data`=0x12345678.
- Lane merge:
  - Word 0x08 = 0x12345678; write `data_byte_we`=0100, `data_wd`=0x00AB0000 → word = 0x12AB5678.
  - Then write 0001, `data_wd`=0x000000CD → word = 0x12AB56CD.
- Write during busy:
  - Assert `reset`, then on the 3rd sweep cycle write 0xFFFFFFFF to 0x3C → no trace.
  - After `busy` falls, 0x3C reads 0.
- Wrap and same-cycle read:
  - Write 0xA5A5A5A5 to 0x48 → word 2 (0x08) reads 0xA5A5A5A5.
  - During the write cycle, `data_rd` shows the prior value.
- Reset mid-sweep:
  - Assert `reset` at sweep cycle 10 → `busy` stays 1 for 16 further cycles after reset drops, and all words read 0.
